// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word width, fetch-stage defaults and IF state type.
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } if_state_t;
endpackage

// File: rtl/mips_pc_reg.sv
// Program counter register: reset, redirect on flush, hold on boot/stall, advance by 4 on ack.
import mips_pkg::*;

module mips_pc_reg #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            boot,
  input  logic            flush,
  input  logic            stall,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (boot)
      pc <= pc;
    else if (flush)
      pc <= target & ~32'h3;
    else if (stall)
      pc <= pc;
    else if (advance)
      pc <= pc_plus4;
    else
      pc <= pc;
  end

endmodule

// File: rtl/mips_if_stage.sv
// MIPS instruction-fetch stage: PC, imem request, IF/ID register.
// Optional perf counters (fetch_cnt, bubble_cnt) enabled by defining IF_PERF_CNT_EN.
//   S_BOOT  | one idle cycle after reset, no request
//   S_FETCH | request issued for pc
//   S_WAIT  | request outstanding, waiting for ack
import mips_pkg::*;

module mips_if_stage #(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic [XLEN-1:0] pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] bubble_cnt
`endif
);

  if_state_t       state, state_nxt;
  logic            active;
  logic [XLEN-1:0] pc_plus4;
  logic            accept;
  logic            bubble;

  assign active    = (state != S_BOOT);
  assign imem_req  = active;
  assign imem_addr = pc;
  assign accept    = active && !flush && !stall && imem_ack;
  assign bubble    = active && (flush || (!stall && !imem_ack));

  mips_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .boot     (!active),
    .flush    (flush),
    .stall    (stall),
    .advance  (imem_ack),
    .target   (branch_target),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (!imem_ack && !flush && !stall) state_nxt = S_WAIT;
      S_WAIT:  if (flush || (!stall && imem_ack)) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_BOOT;
    else
      state <= state_nxt;
  end

  // Flush beats stall: a squashed slot always becomes a bubble.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (accept) begin
      if_id_instr <= imem_rdata;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (accept && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (bubble && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_if_stage.sv
// Randomized scoreboard bench for mips_if_stage against a behavioural fetch model.
module tb_mips_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4, pc;
  logic [31:0] fetch_cnt, bubble_cnt;

  always #5 clk = ~clk;

  mips_if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .pc            (pc)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt)
`endif
  );

`ifndef IF_PERF_CNT_EN
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] pc;
    logic        req;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic        m_valid, m_boot;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model and queue the post-edge expectation.
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic ak, input logic [31:0] tgt);
    exp_t e;
    reset = r; stall = st; flush = fl; imem_ack = ak;
    branch_target = tgt;
    imem_rdata = ak ? mem_word(m_pc) : 32'hDEAD_BEEF;
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_boot = 1; m_fc = 0; m_bc = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (fl) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bc = sat_inc(m_bc);
    end else if (st) begin
      // everything holds
    end else if (ak) begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_valid = 1; m_fc = sat_inc(m_fc);
    end else begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bc = sat_inc(m_bc);
    end
    e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.pc = m_pc;
    e.req = !m_boot; e.fc = m_fc; e.bc = m_bc;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every edge produces one IF/ID update to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 expected=1 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc4",   if_id_pc4,   e.pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        chk("pc",          pc,          e.pc);
        chk("imem_addr",   imem_addr,   e.pc);
        chk("imem_req",    {31'd0, imem_req}, {31'd0, e.req});
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt",   fetch_cnt,   e.fc);
        chk("bubble_cnt",  bubble_cnt,  e.bc);
`endif
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    m_pc = 32'h3000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_boot = 1; m_fc = 0; m_bc = 0;
    // Reset, boot, fetch 0x3000 and 0x3004 with ack tied high
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Three bubbles while waiting at 0x3008, then the ack
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    // Stall two cycles with ack present, then resume
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Flush wins over stall; low address bits masked
    step(0, 1, 1, 1, 32'h0000_3041);
    step(0, 0, 0, 1, 0);
    // PC wrap at the top of the address space
    step(0, 0, 1, 0, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // Mid-run reset while waiting on imem
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           tgt);
    end
    done = 1;
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
